// File: rtl/dra_pkt_sender_if.sv
// Descriptor-FIFO, packet-RAM and TX stream signals of the DRA packet sender.
interface dra_pkt_sender_if #(
  parameter int NUM_PE = 3
);
  logic [NUM_PE-1:0]     empty_despSend;
  logic [NUM_PE-1:0]     rden_despSend;
  logic [NUM_PE*128-1:0] dout_despSend;
  logic [15:0]           addr_pktRAM;
  logic                  wren_pktRAM;
  logic [511:0]          dout_pktRAM;
  logic                  alf_tx;
  logic                  pkt_valid;
  logic [133:0]          pkt;
  logic                  pkt_done;
  logic [1:0]            pkt_pe;
  logic                  err_zero_len;

  modport master (
    input  empty_despSend, dout_despSend, dout_pktRAM, alf_tx,
    output rden_despSend, addr_pktRAM, wren_pktRAM,
    output pkt_valid, pkt, pkt_done, pkt_pe, err_zero_len
  );

  modport slave (
    output empty_despSend, dout_despSend, dout_pktRAM, alf_tx,
    input  rden_despSend, addr_pktRAM, wren_pktRAM,
    input  pkt_valid, pkt, pkt_done, pkt_pe, err_zero_len
  );
endinterface

// File: rtl/dra_pkt_sender.sv
// RR-pops send descriptors and streams pkt RAM lines as 134b tagged beats; head 4 cycles after pop, no bubbles.
// i_alf_tx only blocks the next grant. DRA_TX_STATS_EN adds packet/beat counters.
module dra_pkt_sender #(
  parameter int NUM_PE = 3,
  parameter int ADDR_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dra_pkt_sender_if.master bus
`ifdef DRA_TX_STATS_EN
  ,
  output logic [31:0]      d_pkt_cnt_32b,
  output logic [31:0]      d_beat_cnt_32b
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LAT, S_RD, S_SEND} state_t;
  state_t state_q, state_d;

  logic [1:0]        rr_q, gnt_q, gnt_pe;
  logic              gnt_any;
  logic [NUM_PE-1:0] rden;
  logic [127:0]      desc;
  logic [15:0]       desc_len;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_lo_q;
  logic [12:0]       nbeats_q, beat_q;
  logic [383:0]      line_q;
  logic              err_q;
  logic              sending, last_beat, bump_line;
  logic [127:0]      beat_dat;
  logic [1:0]        tag;
  logic [3:0]        vbytes;
  logic              unused_desc_bits;

  assign desc             = bus.dout_despSend[128*gnt_q +: 128];
  assign desc_len         = desc[31:16];
  assign unused_desc_bits = ^{desc[127:32], desc[15:ADDR_W]};

  // Descending scan so the nearest non-empty PE at/after the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_pe  = rr_q;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (!bus.empty_despSend[(int'(rr_q) + k) % NUM_PE]) begin
        gnt_any = 1'b1;
        gnt_pe  = 2'((int'(rr_q) + k) % NUM_PE);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rden    = '0;
    case (state_q)
      S_IDLE: begin
        if (!bus.alf_tx && gnt_any) begin
          rden[gnt_pe] = 1'b1;
          state_d      = S_POP;
        end
      end
      S_POP:   state_d = (desc_len == 16'd0) ? S_IDLE : S_LAT;
      S_LAT:   state_d = S_RD;
      S_RD:    state_d = S_SEND;
      S_SEND:  if (last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sending   = (state_q == S_SEND);
  assign last_beat = (beat_q == nbeats_q - 13'd1);
  // Next line is requested on beat 3 so it lands exactly for the following beat 0.
  assign bump_line = (beat_q[1:0] == 2'd2) && (({1'b0, beat_q} + 14'd2) < {1'b0, nbeats_q});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_q     <= 2'd0;
      gnt_q    <= 2'd0;
      addr_q   <= '0;
      len_lo_q <= 4'd0;
      nbeats_q <= 13'd0;
      beat_q   <= 13'd0;
      line_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (state_d == S_POP) gnt_q <= gnt_pe;
        S_POP: begin
          addr_q   <= desc[ADDR_W-1:0];
          len_lo_q <= desc_len[3:0];
          nbeats_q <= 13'(({1'b0, desc_len} + 17'd15) >> 4);
          beat_q   <= 13'd0;
          rr_q     <= (int'(gnt_q) == NUM_PE - 1) ? 2'd0 : gnt_q + 2'd1;
          err_q    <= (desc_len == 16'd0);
        end
        S_RD: line_q <= bus.dout_pktRAM[383:0];
        S_SEND: begin
          beat_q <= beat_q + 13'd1;
          if (beat_q[1:0] == 2'd0) line_q <= bus.dout_pktRAM[383:0];
          if (bump_line) addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  // Beat 0 of every line comes straight off the RAM output while the line is captured.
  always_comb begin
    case (beat_q[1:0])
      2'd0:    beat_dat = bus.dout_pktRAM[511:384];
      2'd1:    beat_dat = line_q[383:256];
      2'd2:    beat_dat = line_q[255:128];
      default: beat_dat = line_q[127:0];
    endcase
    if (beat_q == 13'd0) tag = 2'b11;
    else if (last_beat)  tag = 2'b10;
    else                 tag = 2'b01;
    vbytes = last_beat ? (len_lo_q - 4'd1) : 4'hF;
  end

  assign bus.rden_despSend = i_rst ? '0 : rden;
  assign bus.addr_pktRAM   = 16'(addr_q);
  assign bus.wren_pktRAM   = 1'b0;
  assign bus.pkt_valid     = sending;
  assign bus.pkt           = sending ? {tag, vbytes, beat_dat} : '0;
  assign bus.pkt_done      = sending && last_beat;
  assign bus.pkt_pe        = gnt_q;
  assign bus.err_zero_len  = err_q;

`ifdef DRA_TX_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_pkt_cnt_32b  <= 32'd0;
      d_beat_cnt_32b <= 32'd0;
    end else begin
      if (sending)              d_beat_cnt_32b <= d_beat_cnt_32b + 32'd1;
      if (sending && last_beat) d_pkt_cnt_32b  <= d_pkt_cnt_32b + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dra_pkt_sender.sv
// Bench for dra_pkt_sender: queue-style descriptor FIFOs, registered pkt RAM and a per-packet reference model.
module tb_dra_pkt_sender;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dra_pkt_sender_if #(.NUM_PE(3)) bus ();

`ifdef DRA_TX_STATS_EN
  logic [31:0] pkt_cnt, beat_cnt;
`endif

  dra_pkt_sender #(.NUM_PE(3), .ADDR_W(9)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef DRA_TX_STATS_EN
    ,
    .d_pkt_cnt_32b  (pkt_cnt),
    .d_beat_cnt_32b (beat_cnt)
`endif
  );

  logic [511:0] ram  [512];
  logic [127:0] fmem [3][256];
  int wp [3] = '{default: 0};
  int rp [3] = '{default: 0};
  int rr_m = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) bus.dout_pktRAM <= ram[bus.addr_pktRAM[8:0]];

  always @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (bus.rden_despSend[p]) begin
        bus.dout_despSend[p*128 +: 128] <= fmem[p][rp[p] % 256];
        rp[p] <= rp[p] + 1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 3; p++) bus.empty_despSend[p] = (wp[p] == rp[p]);
  end

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input int line, input int len);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, 16'(len), 7'($urandom), 9'(line)};
    fmem[p][wp[p] % 256] = d;
    wp[p] = wp[p] + 1;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < 3; k++)
      if (wp[(rr_m + k) % 3] != rp[(rr_m + k) % 3]) return (rr_m + k) % 3;
    return 0;
  endfunction

  task automatic wait_pop();
    int cyc;
    #1;
    cyc = 0;
    while (bus.rden_despSend == 3'b000 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Expects the next granted packet, checking every beat against the descriptor and RAM image.
  task automatic expect_next(input int alf_beat);
    int p, st, ln, nb, vb, nerr, nval;
    logic [127:0] d, ed, mask;
    logic [1:0]   et;
    wait_pop();
    p = model_grant();
    chk("pop_onehot", 134'(bus.rden_despSend), 134'(3'b001 << p));
    if (bus.rden_despSend == 3'b000) return;
    d    = fmem[p][rp[p] % 256];
    rr_m = (p + 1) % 3;
    st   = int'(d[8:0]);
    ln   = int'(d[31:16]);
    if (ln == 0) begin
      nerr = 0;
      nval = 0;
      repeat (6) begin
        @(negedge clk);
        nerr += int'(bus.err_zero_len);
        nval += int'(bus.pkt_valid);
      end
      chk("zero_len_err_pulses", 134'(nerr), 134'd1);
      chk("zero_len_no_valid", 134'(nval), 134'd0);
      return;
    end
    nb = (ln + 15) / 16;
    repeat (2) @(negedge clk);
    chk("lat_addr", 134'(bus.addr_pktRAM), 134'(st));
    repeat (2) @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      if (b > 0) @(negedge clk);
      if (b == alf_beat) bus.alf_tx = 1'b1;
      et   = (b == 0) ? 2'b11 : ((b == nb - 1) ? 2'b10 : 2'b01);
      vb   = (b == nb - 1) ? (ln - 1) % 16 : 15;
      ed   = ram[(st + b / 4) % 512][511 - 128 * (b % 4) -: 128];
      mask = '1;
      mask = mask << (8 * (15 - vb));
      chk("beat_valid", 134'(bus.pkt_valid), 134'd1);
      chk("beat_tag_vld", 134'(bus.pkt[133:128]), 134'({et, 4'(vb)}));
      chk("beat_data", 134'(bus.pkt[127:0] & mask), 134'(ed & mask));
      chk("beat_done", 134'(bus.pkt_done), 134'(b == nb - 1));
      chk("beat_pe", 134'(bus.pkt_pe), 134'(p));
      if (b % 4 == 3 && b + 1 < nb)
        chk("next_line_addr", 134'(bus.addr_pktRAM), 134'((st + b / 4 + 1) % 512));
    end
    @(negedge clk);
    chk("post_tail_idle", 134'(bus.pkt_valid), 134'd0);
    if (alf_beat >= 0) bus.alf_tx = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rr_m = 0;
  endtask

  initial begin
    int k, line, p;
    rst = 1'b1;
    bus.alf_tx = 1'b0;
    for (int i = 0; i < 512; i++)
      for (int w = 0; w < 16; w++) ram[i][w*32 +: 32] = $urandom;

    // Reset holds every output low even with a descriptor waiting.
    push(0, 5, 64);
    repeat (3) @(negedge clk);
    chk("rst_rden", 134'(bus.rden_despSend), 134'd0);
    chk("rst_valid", 134'(bus.pkt_valid), 134'd0);
    chk("rst_pkt", 134'(bus.pkt), 134'd0);
    chk("rst_done", 134'(bus.pkt_done), 134'd0);
    chk("rst_err", 134'(bus.err_zero_len), 134'd0);
    chk("rst_pe", 134'(bus.pkt_pe), 134'd0);
    chk("rst_addr", 134'(bus.addr_pktRAM), 134'd0);
    chk("rst_wren", 134'(bus.wren_pktRAM), 134'd0);
    rst = 1'b0;
    expect_next(-1);

    push(1, $urandom_range(0, 511), 1);
    expect_next(-1);

    // Strict round robin from a fresh pointer.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 3; q++) push(q, $urandom_range(0, 511), $urandom_range(1, 200));
    repeat (6) expect_next(-1);

    push(2, 511, 100);
    expect_next(-1);

    // Almost-full blocks the grant; raising it mid-packet does not stop the packet.
    bus.alf_tx = 1'b1;
    push(0, $urandom_range(0, 511), 100);
    repeat (8) begin
      @(negedge clk);
      chk("alf_blocks_pop", 134'(bus.rden_despSend), 134'd0);
    end
    bus.alf_tx = 1'b0;
    expect_next(2);

    push(1, 10, 0);
    expect_next(-1);

    // Reset at beat 2 truncates; the following packet starts from a clean state.
    push(2, 7, 128);
    wait_pop();
    p = model_grant();
    chk("trunc_pop", 134'(bus.rden_despSend), 134'(3'b001 << p));
    repeat (6) @(negedge clk);
    chk("trunc_beat2_tag", 134'(bus.pkt[133:132]), 134'(2'b01));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("trunc_valid_low", 134'(bus.pkt_valid), 134'd0);
    chk("trunc_done_low", 134'(bus.pkt_done), 134'd0);
    @(negedge clk);
    rst  = 1'b0;
    rr_m = 0;
    push(1, $urandom_range(0, 511), 50);
    expect_next(-1);

    for (int batch = 0; batch < 8; batch++) begin
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        line = ($urandom_range(0, 3) == 0) ? $urandom_range(508, 511) : $urandom_range(0, 511);
        push($urandom_range(0, 2), line, $urandom_range(1, 300));
      end
      repeat (k) expect_next(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
